// File: rtl/feistel_pkg.sv
// Shared types and bitwise helpers for the iterative Feistel cipher.
// Helpers work on a fixed wide vector and take the active width as an
// argument, so one definition serves every HALF_W up to MAX_W.
package feistel_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // All-ones in the low w bits.
  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Left-rotate the low w bits of x by r (r < w); upper bits come back zero.
  function automatic logic [MAX_W-1:0] rotl_w(input logic [MAX_W-1:0] x,
                                              input int unsigned     w,
                                              input int unsigned     r);
    logic [MAX_W-1:0] xm;
    xm = x & width_mask(w);
    if (r == 0) return xm;
    return ((xm << r) | (xm >> (w - r))) & width_mask(w);
  endfunction

  // Round function F(x) = ~(rotl(x, frot) ^ x), confined to w bits.
  function automatic logic [MAX_W-1:0] f_func(input logic [MAX_W-1:0] x,
                                              input int unsigned     w,
                                              input int unsigned     frot);
    return ~(rotl_w(x, w, frot) ^ x) & width_mask(w);
  endfunction

  // Round key K_i = rotl(k, (krot*i) mod w) ^ i, i truncated to w bits.
  function automatic logic [MAX_W-1:0] round_key(input logic [MAX_W-1:0] k,
                                                 input int unsigned     i,
                                                 input int unsigned     w,
                                                 input int unsigned     krot);
    return rotl_w(k, w, (krot * i) % w) ^ (MAX_W'(i) & width_mask(w));
  endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel step. Encrypt mixes the left half into the new
// left; decrypt undoes that by mixing the right half into the new right.
module feistel_round
  import feistel_pkg::*;
#(
  parameter int HALF_W = 16,
  parameter int F_ROT  = 5
) (
  input  logic [HALF_W-1:0] l_i,
  input  logic [HALF_W-1:0] r_i,
  input  logic [HALF_W-1:0] k_i,
  input  logic              mode_i,
  output logic [HALF_W-1:0] l_o,
  output logic [HALF_W-1:0] r_o
);

  logic [HALF_W-1:0] f_in;
  logic [HALF_W-1:0] f_out;

  // Only one F evaluation is ever needed; pick its operand by direction.
  assign f_in  = mode_i ? r_i : l_i;
  assign f_out = HALF_W'(f_func(MAX_W'(f_in), HALF_W, F_ROT));

  // Select the encrypt or decrypt half permutation.
  always_comb begin
    if (!mode_i) begin
      l_o = r_i ^ f_out ^ k_i;
      r_o = l_i;
    end else begin
      l_o = r_i;
      r_o = l_i ^ f_out ^ k_i;
    end
  end

endmodule

// File: rtl/feistel_iter.sv
// Iterative Feistel cipher: one round per clock, valid/ready on both sides,
// no overlap between jobs. The key schedule is derived on the fly from the
// latched master key and the current round index.
module feistel_iter
  import feistel_pkg::*;
#(
  parameter int HALF_W = 16,
  parameter int ROUNDS = 8,
  parameter int F_ROT  = 5,
  parameter int K_ROT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [2*HALF_W-1:0] p,
  input  logic [HALF_W-1:0]   k,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] c,
  output logic                busy
);

  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [HALF_W-1:0] l_q, l_d, r_q, r_d, key_q, key_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  round_idx;
  logic [HALF_W-1:0] rkey;
  logic [HALF_W-1:0] l_step, r_step;

  // Decrypt walks the key schedule backwards.
  assign round_idx = mode_q ? (LAST - cnt_q) : cnt_q;
  assign rkey      = HALF_W'(round_key(MAX_W'(key_q), int'(round_idx), HALF_W, K_ROT));

  feistel_round #(
    .HALF_W (HALF_W),
    .F_ROT  (F_ROT)
  ) u_round (
    .l_i    (l_q),
    .r_i    (r_q),
    .k_i    (rkey),
    .mode_i (mode_q),
    .l_o    (l_step),
    .r_o    (r_step)
  );

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: latch on accept, step in RUN, hold everything in DONE.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = p[2*HALF_W-1:HALF_W];
          r_d     = p[HALF_W-1:0];
          key_d   = k;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d   = l_step;
        r_d   = r_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags depend on state only; c exposes data only when valid.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c         = (state_q == DONE) ? {l_q, r_q} : '0;

endmodule
